fft8_out_stream: RTL and testbench

FFT8_OUT_STREAM -- requirements
Module: fft8_out_stream

---
 rtl/fft8_out_stream.sv | 107 ++++++++++
 tb/tb_fft8_out_stream.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft8_out_stream.sv
// Streams one captured 8-point FFT result frame as eight valid/ready beats,
// in natural or bit-reversed bin order, with a sticky flag for dropped frames.
module fft8_out_stream #(
    parameter int SIZE_DATA   = 32,
    parameter bit BIT_REVERSE = 1'b0
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_done,
    input  logic [16*SIZE_DATA-1:0] i_X_data,
    input  logic                   i_ready,
    output logic                   o_valid,
    output logic [SIZE_DATA-1:0]   o_real,
    output logic [SIZE_DATA-1:0]   o_imag,
    output logic [2:0]             o_index,
    output logic                   o_last,
    output logic                   o_busy,
    output logic                   o_overrun,
    output logic                   o_dbg_state
);

    // Handshake: a beat moves on a rising edge where o_valid=1 and i_ready=1;
    // while o_valid=1 and i_ready=0 the beat outputs hold; i_ready is a
    // don't-care while o_valid=0.

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t               state_q;
    logic [2:0]           cnt_q;
    logic [SIZE_DATA-1:0] buf_q [16];

    logic                 xfer;
    logic                 last_xfer;
    logic                 capture;
    logic [2:0]           cnt_d;
    logic [2:0]           k_d;
    logic [SIZE_DATA-1:0] buf_re_d;
    logic [SIZE_DATA-1:0] buf_im_d;

    function automatic logic [2:0] beat_to_bin(input logic [2:0] c);
        return BIT_REVERSE ? {c[0], c[1], c[2]} : c;
    endfunction

    always_comb begin
        xfer      = (state_q == SEND) && i_ready;
        last_xfer = xfer && (cnt_q == 3'd7);
        // A new frame is accepted when idle, or exactly as the last beat leaves.
        capture   = i_done && ((state_q == IDLE) || last_xfer);
        cnt_d     = cnt_q + 3'd1;
        k_d       = beat_to_bin(cnt_d);
        buf_re_d  = buf_q[{k_d, 1'b0}];
        buf_im_d  = buf_q[{k_d, 1'b1}];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            for (int i = 0; i < 16; i++) begin
                buf_q[i] <= '0;
            end
            o_valid   <= 1'b0;
            o_real    <= '0;
            o_imag    <= '0;
            o_index   <= 3'd0;
            o_last    <= 1'b0;
            o_busy    <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            if (capture) begin
                for (int i = 0; i < 16; i++) begin
                    buf_q[i] <= i_X_data[i*SIZE_DATA +: SIZE_DATA];
                end
                state_q <= SEND;
                cnt_q   <= 3'd0;
                o_valid <= 1'b1;
                o_busy  <= 1'b1;
                // Beat 0 is bin 0 in either order, so it comes straight from the input.
                o_index <= 3'd0;
                o_real  <= i_X_data[0 +: SIZE_DATA];
                o_imag  <= i_X_data[SIZE_DATA +: SIZE_DATA];
                o_last  <= 1'b0;
            end else if (last_xfer) begin
                state_q <= IDLE;
                o_valid <= 1'b0;
                o_busy  <= 1'b0;
                o_last  <= 1'b0;
            end else if (xfer) begin
                cnt_q   <= cnt_d;
                o_index <= k_d;
                o_real  <= buf_re_d;
                o_imag  <= buf_im_d;
                o_last  <= (cnt_d == 3'd7);
            end

            if ((state_q == SEND) && i_done && !last_xfer) begin
                o_overrun <= 1'b1;
            end
        end
    end

    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_fft8_out_stream.sv
// Directed bench for fft8_out_stream: expected beat tables feed a scoreboard
// queue, checked by a negedge monitor, plus hand-written corner sequences.
module tb_fft8_out_stream;

    localparam int W  = 32;
    localparam int BW = 3 + 2*W + 1;

    typedef struct {
        logic [2:0]   idx;
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic         last;
    } beat_t;

    logic            clk;
    logic            rst_n;
    logic            i_done;
    logic            i_ready;
    logic [16*W-1:0] x_data;

    logic         v0, last0, busy0, ovr0, st0;
    logic [W-1:0] re0, im0;
    logic [2:0]   idx0;
    logic         v1, last1, busy1, ovr1, st1;
    logic [W-1:0] re1, im1;
    logic [2:0]   idx1;

    logic         mon_sel;
    logic         m_valid, m_last, m_busy, m_ovr;
    logic [W-1:0] m_re, m_im;
    logic [2:0]   m_idx;

    int           pass_cnt;
    int           total_cnt;
    logic [BW-1:0] exp_q[$];
    beat_t        tab [40];
    logic [W-1:0] fr_re [8];
    logic [W-1:0] fr_im [8];
    logic [2:0]   br_ord [8];

    fft8_out_stream #(.SIZE_DATA(W), .BIT_REVERSE(1'b0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_done(i_done), .i_X_data(x_data),
        .i_ready(i_ready), .o_valid(v0), .o_real(re0), .o_imag(im0),
        .o_index(idx0), .o_last(last0), .o_busy(busy0), .o_overrun(ovr0),
        .o_dbg_state(st0)
    );

    fft8_out_stream #(.SIZE_DATA(W), .BIT_REVERSE(1'b1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_done(i_done), .i_X_data(x_data),
        .i_ready(i_ready), .o_valid(v1), .o_real(re1), .o_imag(im1),
        .o_index(idx1), .o_last(last1), .o_busy(busy1), .o_overrun(ovr1),
        .o_dbg_state(st1)
    );

    always_comb begin
        m_valid = mon_sel ? v1    : v0;
        m_re    = mon_sel ? re1   : re0;
        m_im    = mon_sel ? im1   : im0;
        m_idx   = mon_sel ? idx1  : idx0;
        m_last  = mon_sel ? last1 : last0;
        m_busy  = mon_sel ? busy1 : busy0;
        m_ovr   = mon_sel ? ovr1  : ovr0;
    end

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [BW-1:0] pack(input beat_t b);
        return {b.idx, b.re, b.im, b.last};
    endfunction

    // driver tasks
    task automatic step(input logic rdy, input logic dn);
        i_ready = rdy;
        i_done  = dn;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic load_frame();
        for (int k = 0; k < 8; k++) begin
            x_data[2*k*W +: W]     = fr_re[k];
            x_data[(2*k+1)*W +: W] = fr_im[k];
        end
    endtask

    task automatic push_range(input int lo, input int n);
        for (int j = lo; j < lo + n; j++) exp_q.push_back(pack(tab[j]));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, BW'(m_valid), BW'(0));
        chk({tag, "_real"},  BW'(m_re),    BW'(0));
        chk({tag, "_imag"},  BW'(m_im),    BW'(0));
        chk({tag, "_index"}, BW'(m_idx),   BW'(0));
        chk({tag, "_last"},  BW'(m_last),  BW'(0));
        chk({tag, "_busy"},  BW'(m_busy),  BW'(0));
        chk({tag, "_ovr"},   BW'(m_ovr),   BW'(0));
    endtask

    // scoreboard monitor: transfers pop the expected queue, stalls must hold
    logic [BW-1:0] held;
    logic          hold_armed;
    initial hold_armed = 1'b0;

    always @(negedge clk) begin
        logic [BW-1:0] cur;
        cur = {m_idx, m_re, m_im, m_last};
        if (rst_n && m_valid) begin
            if (hold_armed) chk("hold_stable", cur, held);
            if (i_ready) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_beat: got %h expected no beat", cur);
                end else begin
                    chk("beat", cur, exp_q.pop_front());
                end
            end
        end
        hold_armed = rst_n && m_valid && !i_ready;
        held       = cur;
    end

    initial begin
        int n;
        int bad;
        pass_cnt  = 0;
        total_cnt = 0;
        mon_sel   = 1'b0;
        rst_n     = 1'b0;
        i_done    = 1'b0;
        i_ready   = 1'b0;
        x_data    = '0;
        br_ord    = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};

        // expected beat tables: [0] DC, [8] backpressure, [16] bit-reversed,
        // [24] ramp natural order, [32] back-to-back frame B
        for (int j = 0; j < 8; j++) begin
            tab[j].idx    = 3'(j);
            tab[j].re     = (j == 0) ? 32'h4100_0000 : 32'h0;
            tab[j].im     = 32'h0;
            tab[j].last   = (j == 7);
            tab[8+j].idx  = 3'(j);
            tab[8+j].re   = 32'(j);
            tab[8+j].im   = 32'(100 + j);
            tab[8+j].last = (j == 7);
            tab[16+j].idx = br_ord[j];
            tab[16+j].re  = 32'(br_ord[j]);
            tab[16+j].im  = 32'h0;
            tab[16+j].last = (j == 7);
            tab[24+j].idx = 3'(j);
            tab[24+j].re  = 32'(j);
            tab[24+j].im  = 32'h0;
            tab[24+j].last = (j == 7);
            tab[32+j].idx = 3'(j);
            tab[32+j].re  = (j == 0) ? 32'h3F80_0000 : 32'(16 + j);
            tab[32+j].im  = 32'(512 + j);
            tab[32+j].last = (j == 7);
        end

        @(posedge clk);
        #1;
        apply_reset();
        chk_all_zero("reset");

        // DC frame, ready held high
        for (int k = 0; k < 8; k++) begin
            fr_re[k] = (k == 0) ? 32'h4100_0000 : 32'h0;
            fr_im[k] = 32'h0;
        end
        load_frame();
        push_range(0, 8);
        step(1'b0, 1'b1);
        chk("dc_latency_valid", BW'(m_valid), BW'(1));
        chk("dc_busy", BW'(m_busy), BW'(1));
        repeat (8) step(1'b1, 1'b0);
        chk("dc_drain", BW'(exp_q.size()), BW'(0));
        chk("dc_valid_after", BW'(m_valid), BW'(0));
        chk("dc_busy_after", BW'(m_busy), BW'(0));

        // backpressure, ready pattern 1,0,0,1,0,0,...
        for (int k = 0; k < 8; k++) begin
            fr_re[k] = 32'(k);
            fr_im[k] = 32'(100 + k);
        end
        load_frame();
        push_range(8, 8);
        step(1'b0, 1'b1);
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            step((n % 3) == 0, 1'b0);
            n++;
        end
        chk("bp_drain", BW'(exp_q.size()), BW'(0));
        chk("bp_valid_after", BW'(m_valid), BW'(0));

        // bit-reversed order
        mon_sel = 1'b1;
        for (int k = 0; k < 8; k++) begin
            fr_re[k] = 32'(k);
            fr_im[k] = 32'h0;
        end
        load_frame();
        push_range(16, 8);
        step(1'b0, 1'b1);
        repeat (8) step(1'b1, 1'b0);
        chk("br_drain", BW'(exp_q.size()), BW'(0));
        chk("br_valid_after", BW'(m_valid), BW'(0));
        mon_sel = 1'b0;

        // overrun: second done during stalled beat 3
        chk("ovr_before", BW'(m_ovr), BW'(0));
        load_frame();
        push_range(24, 8);
        step(1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b0);
        for (int k = 0; k < 8; k++) fr_re[k] = 32'hDEAD_0000 + 32'(k);
        load_frame();
        chk("ovr_at_beat3", BW'(m_idx), BW'(3));
        step(1'b0, 1'b1);
        chk("ovr_set", BW'(m_ovr), BW'(1));
        repeat (5) step(1'b1, 1'b0);
        chk("ovr_drain", BW'(exp_q.size()), BW'(0));
        chk("ovr_valid_after", BW'(m_valid), BW'(0));
        repeat (3) step(1'b0, 1'b0);
        chk("ovr_sticky", BW'(m_ovr), BW'(1));

        // back-to-back frames, done coincident with the beat-7 transfer
        apply_reset();
        chk("ovr_cleared_by_reset", BW'(m_ovr), BW'(0));
        for (int k = 0; k < 8; k++) fr_re[k] = 32'(k);
        load_frame();
        push_range(24, 8);
        push_range(32, 8);
        step(1'b0, 1'b1);
        repeat (7) step(1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            fr_re[k] = (k == 0) ? 32'h3F80_0000 : 32'(16 + k);
            fr_im[k] = 32'(512 + k);
        end
        load_frame();
        chk("b2b_at_last", BW'(m_last), BW'(1));
        step(1'b1, 1'b1);
        chk("b2b_valid", BW'(m_valid), BW'(1));
        chk("b2b_index", BW'(m_idx), BW'(0));
        chk("b2b_real", BW'(m_re), BW'(32'h3F80_0000));
        repeat (8) step(1'b1, 1'b0);
        chk("b2b_drain", BW'(exp_q.size()), BW'(0));
        chk("b2b_ovr", BW'(m_ovr), BW'(0));
        chk("b2b_valid_after", BW'(m_valid), BW'(0));

        // reset mid-frame after beat 2, with done asserted during reset
        for (int k = 0; k < 8; k++) begin
            fr_re[k] = 32'(k);
            fr_im[k] = 32'h0;
        end
        load_frame();
        push_range(24, 3);
        step(1'b0, 1'b1);
        repeat (3) step(1'b1, 1'b0);
        rst_n = 1'b0;
        step(1'b1, 1'b1);
        rst_n = 1'b1;
        chk_all_zero("midrst");
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            step(1'b1, 1'b0);
            if (m_valid) bad++;
        end
        chk("midrst_no_beats", BW'(bad), BW'(0));
        chk("midrst_drain", BW'(exp_q.size()), BW'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
